// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type, boot/NOP constants and address-field width helpers
// for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {IDLE, REFILL} state_e;

   localparam logic [31:0] BOOT_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

   function automatic int offset_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int index_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int lines, input int words_per_line);
      return 30 - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: latches the missing line and walks its words through the
// req/ack memory handshake, emitting per-word write enables and a line-done strobe.
module icache_refill_fsm
   import icache_pkg::*;
#(
   parameter int WORDS_PER_LINE = 4,
   localparam int OW = offset_w(WORDS_PER_LINE),
   localparam int LW = 30 - OW
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          miss_i,
   input  logic [LW-1:0] line_i,
   input  logic          mem_ack_i,
   output logic          mem_req_o,
   output logic [31:0]   mem_addr_o,
   output logic          busy_o,
   output logic          we_o,
   output logic [OW-1:0] word_o,
   output logic          done_o,
   output logic [LW-1:0] line_o
);

   state_e        state_q, state_d;
   logic [OW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] line_q, line_d;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      we_o    = 1'b0;
      done_o  = 1'b0;
      if (state_q == IDLE) begin
         if (miss_i) begin
            state_d = REFILL;
            cnt_d   = '0;
            line_d  = line_i;
         end
      end else if (mem_ack_i) begin
         we_o  = 1'b1;
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   assign busy_o     = (state_q == REFILL);
   assign mem_req_o  = busy_o;
   assign mem_addr_o = {line_q, cnt_q, 2'b00};
   assign word_o     = cnt_q;
   assign line_o     = line_q;

endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache with zero-latency hits and word-by-word refill.
// Define ICACHE_STATS_EN to add the HitCount_OUT/MissCount_OUT counters.
module icache_responder
   import icache_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [31:0] InstructionAddress_IN,
   input  logic        Invalidate_IN,
   output logic [31:0] Instruction_OUT,
   output logic        Stall_OUT,
   output logic        MemReq_OUT,
   output logic [31:0] MemAddr_OUT,
   input  logic        MemAck_IN,
   input  logic [31:0] MemData_IN
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] HitCount_OUT,
   output logic [31:0] MissCount_OUT
`endif
);

   localparam int OW = offset_w(WORDS_PER_LINE);
   localparam int IW = index_w(LINES);
   localparam int TW = tag_w(LINES, WORDS_PER_LINE);
   localparam int LW = TW + IW;

   logic [LINES-1:0] valid_q, valid_d;
   logic             dirty_q, dirty_d;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS_PER_LINE];

   logic [OW-1:0] off, word;
   logic [IW-1:0] idx, widx;
   logic [TW-1:0] tag;
   logic [LW-1:0] line;
   logic          hit, busy, miss, we, done, unused_addr_bits;

   assign off  = InstructionAddress_IN[2 +: OW];
   assign idx  = InstructionAddress_IN[2 + OW +: IW];
   assign tag  = InstructionAddress_IN[31 -: TW];
   assign unused_addr_bits = ^InstructionAddress_IN[1:0];
   assign hit  = valid_q[idx] && (tag_q[idx] == tag);
   assign miss = !busy && !hit;
   assign widx = line[IW-1:0];

   icache_refill_fsm #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_fsm (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .miss_i     (miss),
      .line_i     (InstructionAddress_IN[31 -: LW]),
      .mem_ack_i  (MemAck_IN),
      .mem_req_o  (MemReq_OUT),
      .mem_addr_o (MemAddr_OUT),
      .busy_o     (busy),
      .we_o       (we),
      .word_o     (word),
      .done_o     (done),
      .line_o     (line)
   );

   assign Stall_OUT       = busy || !hit;
   assign Instruction_OUT = Stall_OUT ? NOP_WORD : data_q[idx][off];

   // An invalidate seen at any point of a refill keeps that line from becoming valid.
   assign dirty_d = busy && (dirty_q || Invalidate_IN);

   always_comb begin
      valid_d = Invalidate_IN ? '0 : valid_q;
      if (done && !dirty_q && !Invalidate_IN) valid_d[widx] = 1'b1;
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= '0;
         dirty_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (we) data_q[widx][word] <= MemData_IN;
      if (done) tag_q[widx] <= line[LW-1:IW];
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_q + {31'b0, !busy && hit};
         miss_cnt_q <= miss_cnt_q + {31'b0, miss};
      end
   end

   assign HitCount_OUT  = hit_cnt_q;
   assign MissCount_OUT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: table-driven fetch accesses against a wait-state memory model whose
// request addresses are checked from a scoreboard queue; hand sequences cover reset corners.
module tb_icache_responder;
   import icache_pkg::*;

   localparam int WPL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstructionAddress_IN = '0;
   logic        Invalidate_IN = 1'b0;
   logic [31:0] Instruction_OUT;
   logic        Stall_OUT;
   logic        MemReq_OUT;
   logic [31:0] MemAddr_OUT;
   logic        MemAck_IN = 1'b0;
   logic [31:0] MemData_IN = '0;
`ifdef ICACHE_STATS_EN
   logic [31:0] HitCount_OUT, MissCount_OUT;
`endif

   icache_responder dut (
      .CLOCK                 (clk),
      .RESET                 (rst_n),
      .InstructionAddress_IN (InstructionAddress_IN),
      .Invalidate_IN         (Invalidate_IN),
      .Instruction_OUT       (Instruction_OUT),
      .Stall_OUT             (Stall_OUT),
      .MemReq_OUT            (MemReq_OUT),
      .MemAddr_OUT           (MemAddr_OUT),
      .MemAck_IN             (MemAck_IN),
      .MemData_IN            (MemData_IN)
`ifdef ICACHE_STATS_EN
      ,
      .HitCount_OUT          (HitCount_OUT),
      .MissCount_OUT         (MissCount_OUT)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int wait_n = 0;
   int wcnt = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic [31:0] addr;
      int          wait_n;
      int          inval_at;
      int          n_fill;
      int          exp_stall;
   } vec_t;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {30'b0, a[3:2]} + 32'd1;
      return (a[31:4] == BOOT_VECTOR[31:4]) ? 32'h1111_1111 * w : ~a;
   endfunction

   // Backing memory: acks after wait_n idle cycles, checks each presented address.
   always @(negedge clk) begin
      MemAck_IN = 1'b0;
      if (MemReq_OUT) begin
         if (exp_q.size() == 0) begin
            check("unexpected_req", MemAddr_OUT, 32'hFFFF_FFFF);
         end else begin
            check("mem_addr", MemAddr_OUT, exp_q[0]);
            if (wcnt >= wait_n) begin
               MemAck_IN  = 1'b1;
               MemData_IN = mem_word(MemAddr_OUT);
               void'(exp_q.pop_front());
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic access(input logic [31:0] a, input int w, input int inval_at,
                         input int n_fill, input int exp_stall, input string nm);
      int stalls = 0;
      wait_n = w;
      for (int r = 0; r < n_fill; r++)
         for (int k = 0; k < WPL; k++)
            exp_q.push_back({a[31:4], 4'b0} + 32'(4 * k));
      @(negedge clk);
      rst_n = 1'b1;
      InstructionAddress_IN = a;
      forever begin
         Invalidate_IN = (stalls == inval_at);
         #1;
         if (!Stall_OUT || stalls >= 100) break;
         stalls++;
         @(negedge clk);
      end
      check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
      check({nm, "_instr"}, Instruction_OUT, mem_word({a[31:2], 2'b00}));
      check({nm, "_req_idle"}, {31'b0, MemReq_OUT}, 32'd0);
      check({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   vec_t vecs [14];

   initial begin
      vecs = '{
         '{32'hBFC0_0000, 0, -1, 1, 5},
         '{32'hBFC0_0008, 0, -1, 0, 0},
         '{32'hBFC0_000C, 0, -1, 0, 0},
         '{32'h0000_0040, 3, -1, 1, 17},
         '{32'h0000_0048, 0, -1, 0, 0},
         '{32'h0000_0440, 0, -1, 1, 5},
         '{32'h0000_044C, 0, -1, 0, 0},
         '{32'h0000_0040, 0, -1, 1, 5},
         '{32'hBFC0_0004, 0, -1, 0, 0},
         '{32'h0000_0080, 1, -1, 1, 9},
         '{32'hBFC0_0000, 0,  0, 0, 0},
         '{32'hBFC0_0000, 0, -1, 1, 5},
         '{32'h0000_0100, 0,  2, 2, 10},
         '{32'h0000_0104, 0, -1, 0, 0}
      };
      rst_n = 1'b1;
      InstructionAddress_IN = BOOT_VECTOR;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", {31'b0, MemReq_OUT}, 32'd0);
      check("rst_addr", MemAddr_OUT, 32'd0);
      check("rst_stall", {31'b0, Stall_OUT}, 32'd1);
      check("rst_instr", Instruction_OUT, NOP_WORD);

      foreach (vecs[i])
         access(vecs[i].addr, vecs[i].wait_n, vecs[i].inval_at, vecs[i].n_fill,
                vecs[i].exp_stall, $sformatf("v%0d", i));

      // Reset dropped while the second word of a refill is being acked.
      wait_n = 0;
      for (int k = 0; k < WPL; k++) exp_q.push_back(32'h200 + 32'(4 * k));
      @(negedge clk);
      InstructionAddress_IN = 32'h200;
      Invalidate_IN = 1'b0;
      #1 check("rm_detect_stall", {31'b0, Stall_OUT}, 32'd1);
      @(negedge clk);
      #1 check("rm_word0_addr", MemAddr_OUT, 32'h200);
      @(negedge clk);
      #1 check("rm_word1_addr", MemAddr_OUT, 32'h204);
      check("rm_word1_req", {31'b0, MemReq_OUT}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rm_async_req", {31'b0, MemReq_OUT}, 32'd0);
      check("rm_async_addr", MemAddr_OUT, 32'd0);
      check("rm_async_stall", {31'b0, Stall_OUT}, 32'd1);
      check("rm_async_instr", Instruction_OUT, NOP_WORD);
      exp_q.delete();
      access(32'h200, 0, -1, 1, 5, "rm_restart");

`ifdef ICACHE_STATS_EN
      rst_n = 1'b0;
      #1;
      check("st_rst_hits", HitCount_OUT, 32'd0);
      access(32'h300, 0, -1, 1, 5, "st_miss");
      repeat (10) @(negedge clk);
      #1;
      check("st_hits", HitCount_OUT, 32'd10);
      check("st_misses", MissCount_OUT, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side responder for the fetch stage: receives the fetch address each cycle and returns the instruction word.
- Direct-mapped instruction cache, refilled from a backing memory over a req/ack word handshake.
- Asserts a stall to the pipeline while a miss is being serviced. Fetch holds its program counter during that stall.
- Sits between the fetch stage's address output and the external instruction memory; boot vector 0xBFC00000 is cacheable like any other address.

Parameters:
- LINES, 16, number of cache lines (power of two, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, ≥2)

Ports:
- CLOCK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- InstructionAddress_IN  input  32  fetch address from fetch stage; bits [1:0] ignored
- Invalidate_IN  input  1  clear all valid bits (sampled at posedge)
- Instruction_OUT  output  32  instruction word for current address
- Stall_OUT  output  1  high while the current address cannot be served
- MemReq_OUT  output  1  word read request to backing memory
- MemAddr_OUT  output  32  word address of request, word-aligned
- MemAck_IN  input  1  backing memory accepts request and presents data this cycle
- MemData_IN  input  32  read data, valid when MemAck_IN high

Behaviour:
- Address split:
  - offset = addr[2 +: log2(WORDS_PER_LINE)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Per-line storage: valid bit, tag, and WORDS_PER_LINE data words.
- States:
  - IDLE: lookup is combinational. Hit = valid[index] && tag match. On hit, Instruction_OUT = data[index][offset] and Stall_OUT = 0, in the same cycle (zero-latency hit). On miss, Stall_OUT = 1 combinationally in the same cycle and Instruction_OUT = 32'h0 (NOP); the line-aligned address is latched and the next state is REFILL with word counter = 0.
  - REFILL: MemReq_OUT = 1 and MemAddr_OUT = latched line base + counter*4. Both are held stable until MemAck_IN. On MemAck_IN, MemData_IN is written to word[counter] and the counter increments. When the last word is acked, tag and valid are written and the next state is IDLE. Stall_OUT = 1 and Instruction_OUT = 0 throughout REFILL. The first IDLE cycle after refill hits.
- Miss penalty with a 0-wait memory: 1 detect cycle + WORDS_PER_LINE ack cycles. Stall_OUT drops in the cycle after the last ack.
- MemReq_OUT deasserts in the cycle after the final ack. Back-to-back requests within a line are allowed: req stays high and the address advances the cycle after each ack.
- InstructionAddress_IN changes during REFILL are ignored; the refill completes for the latched line. The IDLE lookup then uses the new address.
- Invalidate_IN:
  - In IDLE: all valid bits are cleared at the edge.
  - During REFILL: valid bits are cleared; the in-flight line is marked valid at completion only if no invalidate occurred during its refill. The refill itself always finishes, so the memory handshake is never abandoned.
- Reset (asynchronous, any state, including mid-refill):
  - state = IDLE, counter = 0, all valid = 0
  - MemReq_OUT = 0, MemAddr_OUT = 0
  - data/tag arrays are not reset
  - Outputs immediately after reset: Stall_OUT = 1 (reset miss) for any address, Instruction_OUT = 0.
- Tag compare uses full tag width; no partial matching. Wrap-around of the line base at 0xFFFFFFF0 is not possible because lines are aligned.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds output ports HitCount_OUT[31:0] and MissCount_OUT[31:0].
  - HitCount increments on each IDLE cycle with a hit. MissCount increments once per refill start.
  - Both counters wrap at 2^32 and are zeroed by RESET. Invalidate_IN does not clear them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, REFILL}
  - BOOT_VECTOR = 32'hBFC00000
  - NOP_WORD = 32'h0
  - functions deriving INDEX_W, OFFSET_W, TAG_W from the parameters
- One natural sub-module: icache_refill_fsm. It owns the state, counter, latched line address and memory handshake, and emits write-enable, word index and line-done to the storage in icache_responder.

Test Plan:
- After reset, address 0xBFC00000, memory returns 0x11111111..0x44444444 with 0 wait: Stall_OUT=1 for 5 cycles, MemAddr_OUT sequence BFC00000, BFC00004, BFC00008, BFC0000C; then Instruction_OUT=0x11111111 with Stall_OUT=0. Address 0xBFC00008 next cycle gives 0x33333333, no stall.
- MemAck_IN delayed 3 cycles per word: MemReq_OUT and MemAddr_OUT held constant while waiting; total stall = 1+4*4 = 17 cycles.
- Conflict, LINES=16, WPL=4: fill 0x00000040, then access 0x00000440 (same index 4, different tag) → miss and refill. Returning to 0x00000040 → miss again.
- Invalidate_IN pulsed after filling 0xBFC00000 → the next access to 0xBFC00000 misses. Invalidate pulsed mid-refill → that line misses again after completion.
- RESET dropped during the 2nd word of a refill: MemReq_OUT=0 asynchronously. After release, the same address restarts its refill from word 0.
- With ICACHE_STATS_EN defined: 1 miss followed by 10 hit cycles gives MissCount_OUT=1 and HitCount_OUT=10.
